shift_left_seq: RTL and testbench

Sequential lane-granular left shifter: the opposite-direction counterpart of the combinational `shift_right` datapath block. It accepts a 50-bit word as ten 5-bit lanes, a lane shift count and a 5-bit fill pattern over a valid/ready handshake. It shifts the word left one lane per clock, inserting the fill pattern into each vacated low lane. It returns the result over a second valid/ready handshake. It sits on the pack/realign side of the datapath, where the right shifter handles unpack.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shl_lane_step.sv | 18 +
 rtl/shift_left_seq.sv | 136 +++++++++++++
 tb/tb_shift_left_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | shift_pkg
// | Shared lane/word types, sizes and FSM states for the lane shifters.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package shift_pkg;

    localparam int LANE_W    = 5;
    localparam int LANES     = 10;
    localparam int SHIFT_MAX = 4;
    localparam int WORD_W    = LANE_W * LANES;
    localparam int SHIFT_W   = 3;

    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [SHIFT_W-1:0] shamt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shl_lane_step.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | shl_lane_step
// | Combinational one-lane left step: top lane dropped, fill enters lane 0.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module shl_lane_step
    import shift_pkg::*;
(
    input  word_t data,
    input  lane_t fill,
    output word_t shifted
);

    assign shifted = {data[WORD_W-LANE_W-1:0], fill};

endmodule : shl_lane_step
`default_nettype wire

// File: rtl/shift_left_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | shift_left_seq
// | Lane-granular left shifter with valid/ready in and out; one lane per clock,
// | or the whole shift in one step when SHIFT_LEFT_ONESHOT_EN is defined.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module shift_left_seq
    import shift_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  word_t  in,
    input  shamt_t shift,
    input  lane_t  fill,
    output logic   out_valid,
    input  logic   out_ready,
    output word_t  out,
    output logic   out_err
);

    state_t r_state;
    state_t w_state_nxt;
    word_t  r_data;
    lane_t  r_fill;
    shamt_t r_cnt;
    logic   r_err;

    word_t  w_load;
    word_t  w_step;
    logic   w_illegal;
    logic   w_direct;

    assign w_illegal = (shift > shamt_t'(SHIFT_MAX));

`ifdef SHIFT_LEFT_ONESHOT_EN
    word_t w_chain [0:SHIFT_MAX];

    assign w_chain[0] = in;

    generate
        for (genvar k = 0; k < SHIFT_MAX; k++) begin : g_chain
            shl_lane_step u_step (
                .data    (w_chain[k]),
                .fill    (fill),
                .shifted (w_chain[k+1])
            );
        end
    endgenerate

    // Illegal counts must leave the word untouched, so bypass the chain
    assign w_load   = w_illegal ? in : w_chain[shift];
    assign w_step   = r_data;
    assign w_direct = 1'b1;
`else
    shl_lane_step u_step (
        .data    (r_data),
        .fill    (r_fill),
        .shifted (w_step)
    );

    assign w_load   = in;
    assign w_direct = (shift == '0) || w_illegal;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_direct ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == shamt_t'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= w_load;
                        r_fill <= fill;
                        r_cnt  <= shift;
                        r_err  <= w_illegal;
                    end
                end
                SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - shamt_t'(1);
                end
                DONE: begin
                    if (out_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out     = r_data;
    assign out_err = r_err;

endmodule : shift_left_seq
`default_nettype wire

// File: tb/tb_shift_left_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_shift_left_seq
// | Self-checking bench for shift_left_seq against a lane-array reference model.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_shift_left_seq;
    import shift_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid;
    logic   in_ready;
    word_t  din;
    shamt_t shift;
    lane_t  fill;
    logic   out_valid;
    logic   out_ready;
    word_t  dout;
    logic   out_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        word_t d;
        logic  e;
    } result_t;

    result_t sb_q[$];

    shift_left_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .shift     (shift),
        .fill      (fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic word_t rand_word();
        return word_t'({$urandom(), $urandom()});
    endfunction

    // Reference: lane j takes input lane j-s, vacated low lanes take fill
    function automatic word_t model(word_t d, shamt_t s, lane_t f);
        word_t r;
        int    si;
        r  = d;
        si = int'(s);
        if (si <= SHIFT_MAX) begin
            for (int j = 0; j < LANES; j++) begin
                if (j < si) r[j*LANE_W +: LANE_W] = f;
                else        r[j*LANE_W +: LANE_W] = d[(j-si)*LANE_W +: LANE_W];
            end
        end
        return r;
    endfunction

    function automatic int exp_lat(shamt_t s);
`ifdef SHIFT_LEFT_ONESHOT_EN
        return (s == s) ? 1 : 1;
`else
        return (int'(s) <= SHIFT_MAX) ? int'(s) + 1 : 1;
`endif
    endfunction

    task automatic accept(input word_t d, input shamt_t s, input lane_t f, output bit ok);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok       = in_ready;
        din      = d;
        shift    = s;
        fill     = f;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        din      = rand_word();
        shift    = shamt_t'($urandom_range(0, 7));
        fill     = lane_t'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = rand_word();
        shift     = '0;
        fill      = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (dout !== '0)        begin n_fail++; $display("FAIL rst_out got=%h exp=0", dout); end
        n_checks++; if (out_err !== 1'b0)   begin n_fail++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (dout !== '0)        begin n_fail++; $display("FAIL post_rst_out got=%h exp=0", dout); end
        n_checks++; if (out_err !== 1'b0)   begin n_fail++; $display("FAIL post_rst_out_err got=%b exp=0", out_err); end
    endtask

    task automatic test_shift0();
        word_t d;
        bit    ok;
        int    lat;
        d = 50'h2_AAAA_BBBB_CCCC;
        accept(d, 3'd0, 5'h1F, ok);
        wait_done(lat);
        n_checks++; if (ok !== 1'b1)       begin n_fail++; $display("FAIL s0_accept got=%b exp=1", ok); end
        n_checks++; if (lat !== exp_lat(3'd0)) begin n_fail++; $display("FAIL s0_latency got=%0d exp=%0d", lat, exp_lat(3'd0)); end
        n_checks++; if (dout !== d)        begin n_fail++; $display("FAIL s0_out got=%h exp=%h", dout, d); end
        n_checks++; if (out_err !== 1'b0)  begin n_fail++; $display("FAIL s0_err got=%b exp=0", out_err); end
        take();
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL s0_release got=%b exp=10", {in_ready, out_valid}); end
    endtask

    task automatic test_shift4();
        word_t d;
        word_t e;
        bit    ok;
        int    lat;
        for (int k = 0; k < LANES; k++) begin
            d[k*LANE_W +: LANE_W] = lane_t'(k);
            e[k*LANE_W +: LANE_W] = (k >= 4) ? lane_t'(k - 4) : 5'h15;
        end
        accept(d, 3'd4, 5'h15, ok);
        wait_done(lat);
        n_checks++; if (ok !== 1'b1)      begin n_fail++; $display("FAIL s4_accept got=%b exp=1", ok); end
`ifdef SHIFT_LEFT_ONESHOT_EN
        n_checks++; if (lat !== 1)        begin n_fail++; $display("FAIL s4_latency got=%0d exp=1", lat); end
`else
        n_checks++; if (lat !== 5)        begin n_fail++; $display("FAIL s4_latency got=%0d exp=5", lat); end
`endif
        n_checks++; if (dout !== e)       begin n_fail++; $display("FAIL s4_out got=%h exp=%h", dout, e); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL s4_err got=%b exp=0", out_err); end
        take();
    endtask

    task automatic test_illegal();
        word_t d;
        bit    ok;
        int    lat;
        d = rand_word();
        accept(d, 3'd6, lane_t'($urandom), ok);
        wait_done(lat);
        n_checks++; if (lat !== 1)        begin n_fail++; $display("FAIL ill_latency got=%0d exp=1", lat); end
        n_checks++; if (dout !== d)       begin n_fail++; $display("FAIL ill_out got=%h exp=%h", dout, d); end
        n_checks++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL ill_err got=%b exp=1", out_err); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, out_err, dout} !== {1'b1, 1'b1, d}) begin
                n_fail++;
                $display("FAIL ill_hold cyc=%0d got v=%b e=%b out=%h exp v=1 e=1 out=%h", c, out_valid, out_err, dout, d);
            end
        end
        take();
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL ill_err_clear got=%b exp=0", out_err); end
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL ill_release got=%b exp=10", {in_ready, out_valid}); end
    endtask

    task automatic test_reset_mid();
        word_t d;
        lane_t f;
        bit    ok;
        int    lat;
        accept(rand_word(), 3'd3, lane_t'($urandom), ok);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({in_ready, out_valid, out_err} !== 3'b100) begin n_fail++; $display("FAIL mid_rst_ctrl got=%b exp=100", {in_ready, out_valid, out_err}); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL mid_rst_out got=%h exp=0", dout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        d = rand_word();
        f = lane_t'($urandom);
        accept(d, 3'd1, f, ok);
        wait_done(lat);
        n_checks++; if (lat !== exp_lat(3'd1)) begin n_fail++; $display("FAIL mid_s1_latency got=%0d exp=%0d", lat, exp_lat(3'd1)); end
        n_checks++; if (dout !== model(d, 3'd1, f)) begin n_fail++; $display("FAIL mid_s1_out got=%h exp=%h", dout, model(d, 3'd1, f)); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL mid_s1_err got=%b exp=0", out_err); end
        take();
    endtask

    task automatic test_back_to_back();
        result_t r;
        int      n_out;
        int      n_in;
        n_out = 0;
        n_in  = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            out_ready = (cyc >= 860) ? 1'b1 : 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious cyc=%0d got out=%h err=%b exp none", cyc, dout, out_err);
                end else begin
                    r = sb_q.pop_front();
                    n_out++;
                    if ({dout, out_err} !== {r.d, r.e}) begin
                        n_fail++;
                        $display("FAIL b2b_result cyc=%0d got out=%h err=%b exp out=%h err=%b", cyc, dout, out_err, r.d, r.e);
                    end
                end
            end
            in_valid = (cyc < 840) ? 1'($urandom_range(0, 1)) : 1'b0;
            din      = rand_word();
            shift    = shamt_t'($urandom_range(0, 7));
            fill     = lane_t'($urandom);
            if (in_valid && in_ready) begin
                r.d = model(din, shift, fill);
                r.e = (int'(shift) > SHIFT_MAX);
                sb_q.push_back(r);
                n_in++;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain got=%0d pending exp=0", sb_q.size()); end
        n_checks++; if (n_out != n_in || n_in < 20) begin n_fail++; $display("FAIL b2b_count got out=%0d in=%0d exp equal and >=20", n_out, n_in); end
    endtask

    initial begin
        test_reset();
        test_shift0();
        test_shift4();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_left_seq
`default_nettype wire
